spi_dac_tx: RTL

- Output-side transmitter that takes the 10-bit sample produced by the processor stage (data_out plus its enable strobe) and shifts it serially into an MCP4911-class 10-bit SPI DAC.
- It then pulses the DAC latch (LDAC) so that the analogue output updates.
- It sits between the processor and the DAC pins, and completes each frame well inside one 10 kHz sample period at a 50 MHz sysclk.

---
 rtl/spi_dac_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_dac_tx.sv
// rtl/spi_dac_tx.sv - serialises a 10-bit sample into an MCP4911-class SPI DAC and strobes LDAC
module spi_dac_tx #(
  parameter int   CLK_DIV = 25,
  parameter logic BUF     = 1'b0,
  parameter logic GA_N    = 1'b1,
  parameter logic SHDN_N  = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       dac_cs,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CS_HIGH, S_LATCH} state_t;

  // Last count of a CLK_DIV-long phase; divider restarts at 0 on every phase entry.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  logic [15:0] r_shift;
  logic [3:0]  r_bit;
  logic [7:0]  r_div;
  logic        r_cs;
  logic        r_sck;
  logic        r_sdi;
  logic        r_ld;
  logic        r_busy;
  logic        r_done;

  logic [15:0] w_frame;
  logic        w_div_end;

  assign w_frame   = {1'b0, BUF, GA_N, SHDN_N, data_in, 2'b00};
  assign w_div_end = (r_div == DIV_LAST);

  assign dac_cs  = r_cs;
  assign dac_sck = r_sck;
  assign dac_sdi = r_sdi;
  assign dac_ld  = r_ld;
  assign busy    = r_busy;
  assign done    = r_done;

  // Frame sequencer: shift 16 bits, raise CS, pulse LDAC, then report done.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_cs    <= 1'b1;
      r_sck   <= 1'b0;
      r_sdi   <= 1'b0;
      r_ld    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= w_frame;
            r_sdi   <= w_frame[15];
            r_bit   <= 4'd15;
            r_div   <= '0;
            r_cs    <= 1'b0;
            r_sck   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= '0;
            if (!r_sck) begin
              // Rising edge: the DAC samples the bit held since the low phase began.
              r_sck <= 1'b1;
            end else if (r_bit == 4'd0) begin
              r_sck   <= 1'b0;
              r_cs    <= 1'b1;
              r_sdi   <= 1'b0;
              r_state <= S_CS_HIGH;
            end else begin
              // Falling edge starts the next bit; SDI only ever moves here.
              r_sck   <= 1'b0;
              r_bit   <= r_bit - 4'd1;
              r_sdi   <= r_shift[14];
              r_shift <= {r_shift[14:0], 1'b0};
            end
          end
        end
        S_CS_HIGH: begin
          if (!w_div_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div   <= '0;
            r_ld    <= 1'b0;
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (!w_div_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div   <= '0;
            r_ld    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
